// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a write-back scoreboard (pending bit per register).
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_rd,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;

  always_comb begin
    pend_nxt = pending;
    cnt_nxt  = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (flush)
        pend_nxt[r] = 1'b0;
      else if (iss_valid && iss_rd == AW'(r))
        pend_nxt[r] = 1'b1;
      else if ((wa_en && wa_rd == AW'(r)) || (wb_en && wb_rd == AW'(r)))
        pend_nxt[r] = 1'b0;
    end
    pend_nxt[0] = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++)
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[r]);
  end

  // Port B is written after port A so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '{default: '0};
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
      if (wa_en && wa_rd != '0) regs[wa_rd] <= wa_data;
      if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;
    end
  end

  // regs[0] is never written, so address 0 reads as zero without a special case.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < NRD; i++) begin
        rs_data[i*XLEN +: XLEN] = regs[rs_addr[i*AW +: AW]];
        rs_busy[i]              = pending[rs_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (rs_addr[i*AW +: AW] != '0) begin
          if (wb_en && wb_rd == rs_addr[i*AW +: AW]) begin
            rs_data[i*XLEN +: XLEN] = wb_data;
            rs_busy[i]              = 1'b0;
          end else if (wa_en && wa_rd == rs_addr[i*AW +: AW]) begin
            rs_data[i*XLEN +: XLEN] = wa_data;
            rs_busy[i]              = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
